// File: rtl/cic_ctrl_if.sv
// Bus bundle for cic_ctrl: run control, CIC strobe/data, and the output
// stream handshake. slave is the controller's view, master the driver's view.
interface cic_ctrl_if #(
    parameter int WIDTH = 24
);
    logic             enable;
    logic [7:0]       ratio;
    logic             dec_en;
    logic [WIDTH-1:0] dec_in;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             running;
    logic [7:0]       ovf_cnt;

    modport slave (
        input  enable, ratio, dec_in, dout_ready,
        output dec_en, dout, dout_valid, running, ovf_cnt
    );

    modport master (
        output enable, ratio, dec_in, dout_ready,
        input  dec_en, dout, dout_valid, running, ovf_cnt
    );
endinterface

// File: rtl/cic_ctrl.sv
// CIC decimator controller: issues the decimation strobe, discards the
// settling samples and buffers results in a 2-entry FIFO. Drop counter: CIC_CTRL_OVF_CNT_EN.
module cic_ctrl #(
    parameter int WIDTH  = 24,
    parameter int STAGES = 3
) (
    input  logic      clk,
    input  logic      rst,
    cic_ctrl_if.slave bus
);
    localparam int DW = (STAGES > 0) ? $clog2(STAGES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       phase_q, phase_d;
    logic [7:0]       ratio_q, ratio_d;
    logic [DW-1:0]    disc_q, disc_d;
    logic             cap_q;
    logic             dec_en;
    logic             capture;
    logic             push;
    logic             pop;
    logic             full;
    logic             do_write;
    logic [7:0]       ratio_clamped;
    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;

    assign ratio_clamped = (bus.ratio < 8'd2) ? 8'd2 : bus.ratio;
    assign dec_en        = (state_q != IDLE) && (phase_q == ratio_q - 8'd1);
    // The word arrives one cycle after the strobe; it only counts while active.
    assign capture       = cap_q && (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        ratio_d = ratio_q;
        disc_d  = disc_q;
        push    = 1'b0;

        unique case (state_q)
            IDLE: begin
                phase_d = 8'd0;
                if (bus.enable) begin
                    state_d = WARMUP;
                    ratio_d = ratio_clamped;
                    disc_d  = DW'(STAGES);
                end
            end
            WARMUP: begin
                // The first kept sample is pushed here, so running rises with its dout_valid.
                if (capture) begin
                    if (disc_q != '0) begin
                        disc_d = disc_q - DW'(1);
                    end else begin
                        push    = 1'b1;
                        state_d = RUN;
                    end
                end else if (STAGES == 0) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                push = capture;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q != IDLE) begin
            phase_d = (phase_q == ratio_q - 8'd1) ? 8'd0 : phase_q + 8'd1;
            if (!bus.enable) begin
                state_d = IDLE;
                phase_d = 8'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= 8'd0;
            ratio_q <= 8'd2;
            disc_q  <= '0;
            cap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ratio_q <= ratio_d;
            disc_q  <= disc_d;
            cap_q   <= dec_en;
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop      = (count_q != 2'd0) && bus.dout_ready;
    assign full     = (count_q == 2'd2);
    assign do_write = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= bus.dec_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_write) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_write} - {1'b0, pop};
        end
    end

    assign bus.dec_en     = dec_en;
    assign bus.dout_valid = (count_q != 2'd0);
    assign bus.dout       = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
    assign bus.running    = (state_q == RUN);

`ifdef CIC_CTRL_OVF_CNT_EN
    logic       drop;
    logic [7:0] ovf_q;

    assign drop = push && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 8'd0;
        end else if (drop && (ovf_q != 8'hFF)) begin
            ovf_q <= ovf_q + 8'd1;
        end
    end

    assign bus.ovf_cnt = ovf_q;
`else
    assign bus.ovf_cnt = 8'd0;
`endif

endmodule
